pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_if.sv | 34 +++
 rtl/pipe_adder.sv | 95 +++++++++
 tb/tb_pipe_adder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; the optional sub select exists only with PIPE_ADDER_SUB_EN.
interface pipe_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport slave (
`ifdef PIPE_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );

    modport master (
`ifdef PIPE_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Carry-segmented pipelined adder (subtract mode with PIPE_ADDER_SUB_EN); latency STAGES cycles.
// Whole pipeline freezes while out_valid & !out_ready; in_ready = that advance condition, forced 0 in reset.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);
    localparam int ST  = (STAGES < 1) ? 1 : STAGES;
    localparam int SEG = WIDTH / ST;

    generate
        if (STAGES < 1 || (WIDTH % ST) != 0) begin : g_bad_cfg
            $error("pipe_adder: WIDTH must be a positive multiple of STAGES");
        end
    endgenerate

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
    } stage_t;

    stage_t           st_q  [ST];
    stage_t           st_in [ST];
    stage_t           st_nx [ST];
    logic [SEG:0]     seg_sum [ST];
    logic [ST-1:0]    vld_q;
    logic             ovf_q;
    logic             ovf_nx;
    logic             adv;
    logic [WIDTH-1:0] b_op;
    logic             c_op;

    // Subtraction is folded into stage 0: the inverted B travels down the pipe.
    always_comb begin
`ifdef PIPE_ADDER_SUB_EN
        b_op = bus.sub ? ~bus.B   : bus.B;
        c_op = bus.sub ? ~bus.Cin : bus.Cin;
`else
        b_op = bus.B;
        c_op = bus.Cin;
`endif
    end

    always_comb begin
        st_in[0].a = bus.A;
        st_in[0].b = b_op;
        st_in[0].s = '0;
        st_in[0].c = c_op;
        for (int k = 1; k < ST; k++) begin
            st_in[k] = st_q[k-1];
        end
        for (int k = 0; k < ST; k++) begin
            seg_sum[k] = {1'b0, st_in[k].a[k*SEG +: SEG]}
                       + {1'b0, st_in[k].b[k*SEG +: SEG]}
                       + {{SEG{1'b0}}, st_in[k].c};
            st_nx[k]   = st_in[k];
            st_nx[k].s[k*SEG +: SEG] = seg_sum[k][SEG-1:0];
            st_nx[k].c = seg_sum[k][SEG];
        end
        // a^b^s at the MSB recovers the carry into the MSB.
        ovf_nx = st_nx[ST-1].a[WIDTH-1] ^ st_nx[ST-1].b[WIDTH-1]
               ^ st_nx[ST-1].s[WIDTH-1] ^ st_nx[ST-1].c;
    end

    assign adv           = !vld_q[ST-1] | bus.out_ready;
    assign bus.in_ready  = adv & !rst;
    assign bus.out_valid = vld_q[ST-1];
    assign bus.S         = st_q[ST-1].s;
    assign bus.Cout      = st_q[ST-1].c;
    assign bus.Ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < ST; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= bus.in_valid;
            for (int k = 1; k < ST; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < ST; k++) begin
                st_q[k] <= st_nx[k];
            end
            ovf_q <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder at WIDTH=32, STAGES=4.
module tb_pipe_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipe_adder_if #(.WIDTH(32)) bus ();

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One isolated beat; result must appear exactly 4 cycles after acceptance.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub_sel, input logic [31:0] exp_s,
                            input logic exp_c, input logic exp_o);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
`ifdef PIPE_ADDER_SUB_EN
        bus.sub      = sub_sel;
`else
        if (sub_sel) $display("note: sub ignored in this build");
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check({tag, "_vld"}, {31'b0, bus.out_valid}, {31'b0, (i == 4)});
        end
        check({tag, "_S"},    bus.S,            exp_s);
        check({tag, "_Cout"}, {31'b0, bus.Cout}, {31'b0, exp_c});
        check({tag, "_Ovf"},  {31'b0, bus.Ovf},  {31'b0, exp_o});
`ifdef PIPE_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
    endtask

    logic [31:0] exp_bp [5];
    int          got;
    int          vld_cnt;
    logic        acc;

    initial begin
        exp_bp[0] = 32'h1;  exp_bp[1] = 32'h11; exp_bp[2] = 32'h21;
        exp_bp[3] = 32'h31; exp_bp[4] = 32'h41;

        // Reset with a beat offered: it must be ignored.
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.A = 32'h5; bus.B = 32'h6; bus.Cin = 1'b0;
        bus.out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'b0, bus.in_ready},  32'h0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_S",         bus.S,                  32'h0);
        check("rst_Cout",      {31'b0, bus.Cout},      32'h0);
        check("rst_Ovf",       {31'b0, bus.Ovf},       32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        vld_cnt = 0;
        repeat (6) begin @(negedge clk); if (bus.out_valid) vld_cnt++; end
        check("rst_beat_ignored", vld_cnt, 0);

        // Wrap, signed overflow both ways, cross-segment carry with Cin.
        send_one("wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send_one("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        send_one("ovf_neg", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
        send_one("cin",     32'h12345678, 32'h0000FFFF, 1'b1, 1'b0, 32'h12355678, 1'b0, 1'b0);

        // Ten back-to-back beats: result of beat t-4 visible in iteration t.
        @(posedge clk); #1;
        vld_cnt = 0;
        for (int t = 0; t < 15; t++) begin
            bus.in_valid = (t < 10);
            bus.A        = t;
            bus.B        = 2 * t;
            bus.Cin      = 1'b0;
            @(negedge clk);
            check("b2b_vld", {31'b0, bus.out_valid}, {31'b0, (t >= 4 && t < 14)});
            if (t >= 4 && t < 14) begin
                check("b2b_S", bus.S, 3 * (t - 4));
                if (bus.out_valid) vld_cnt++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("b2b_count", vld_cnt, 10);

        // Backpressure: fill with out_ready low, hold, then drain in order.
        bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.in_valid = 1'b1; bus.A = 16 * j; bus.B = 32'h1; bus.Cin = 1'b0;
            @(posedge clk); #1;
        end
        bus.A = 32'h40;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready",  {31'b0, bus.in_ready},  32'h0);
            check("bp_out_valid", {31'b0, bus.out_valid}, 32'h1);
            check("bp_S_hold",    bus.S,                  exp_bp[0]);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got < 5; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                check("bp_drain_S", bus.S, exp_bp[got]);
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) bus.in_valid = 1'b0;
        end
        check("bp_drain_count", got, 5);
        @(negedge clk);
        check("bp_no_dup", {31'b0, bus.out_valid}, 32'h0);

        // Reset pulse with two beats in flight.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.A = 32'hAA; bus.B = 32'h11;
        @(posedge clk); #1;
        bus.A = 32'hBB;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        vld_cnt = 0;
        repeat (8) begin @(negedge clk); if (bus.out_valid) vld_cnt++; end
        check("midrst_flushed", vld_cnt, 0);
        send_one("after_rst", 32'h3, 32'h4, 1'b1, 1'b0, 32'h8, 1'b0, 1'b0);

`ifdef PIPE_ADDER_SUB_EN
        send_one("sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        send_one("sub_pos", 32'h7, 32'h5, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
